// File: rtl/discharge_pkg.sv
// Shared definitions for the EDM discharge-control path: discharge FSM state
// codes, waveform control bit positions and the gap classifier state encoding.
package discharge_pkg;

  localparam logic [7:0] S_WAIT_BREAKDOWN    = 8'b00000001;
  localparam logic [7:0] S_BUCK_INTERLEAVE   = 8'b00000010;
  localparam logic [7:0] S_RES_DISCHARGE     = 8'b00000100;
  localparam logic [7:0] S_DEION             = 8'b10000000;
  localparam logic [7:0] S_DEION_SINGLE_BUCK = 8'b00000000;

  localparam int BUCK_OR_RES_BIT        = 15;
  localparam int CONTINUE_OR_SINGLE_BIT = 14;
  localparam int OPEN_OR_CLOSE_BIT      = 13;

  // Slot of each run-length qualifier inside the classifier.
  localparam int QUAL_BD    = 0;
  localparam int QUAL_SHORT = 1;
  localparam int NUM_QUAL   = 2;

  typedef enum logic [1:0] {
    G_IDLE,
    G_BLANK,
    G_DETECT,
    G_DONE
  } gap_state_e;

endpackage

// File: rtl/run_length_qualifier.sv
// Saturating consecutive-cycle counter; 'qualified' is asserted combinationally
// during the cycle whose sample completes a run of 'threshold' (0 acts as 1).
module run_length_qualifier #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cond,
  input  logic [CNT_W-1:0] threshold,
  output logic             qualified
);

  logic [CNT_W-1:0] run_reg;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] thr_eff;

  always_comb begin
    thr_eff  = (threshold == '0) ? CNT_W'(1) : threshold;
    run_next = (run_reg == '1) ? run_reg : run_reg + CNT_W'(1);
  end

  assign qualified = enable && cond && (run_next >= thr_eff);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      run_reg <= '0;
    end else if (cond) begin
      run_reg <= run_next;
    end else begin
      run_reg <= '0;
    end
  end

endmodule

// File: rtl/discharge_gap_classifier.sv
// Classifies the gap during S_WAIT_BREAKDOWN as breakdown, short or open-circuit
// timeout, and measures the ignition delay from window start.
module discharge_gap_classifier #(
  parameter int         DATA_W              = 16,
  parameter int         CNT_W               = 16,
  parameter logic [7:0] S_WAIT_BREAKDOWN    = 8'b00000001,
  parameter logic [7:0] S_DEION             = 8'b10000000,
  parameter logic [7:0] S_DEION_SINGLE_BUCK = 8'b00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_current,
  input  logic [DATA_W-1:0] sample_voltage,
  input  logic [7:0]        current_state,
  input  logic [DATA_W-1:0] cfg_bd_cur,
  input  logic [DATA_W-1:0] cfg_bd_vol,
  input  logic [DATA_W-1:0] cfg_deion_vol,
  input  logic [CNT_W-1:0]  cfg_bd_time,
  input  logic [CNT_W-1:0]  cfg_short_time,
  input  logic [CNT_W-1:0]  cfg_blank_time,
  input  logic [CNT_W-1:0]  cfg_timeout,
  output logic              is_breakdown,
  output logic              is_short,
  output logic              is_open_timeout,
  output logic              result_valid,
  output logic [CNT_W-1:0]  ignition_delay
);
  import discharge_pkg::gap_state_e;
  import discharge_pkg::G_IDLE;
  import discharge_pkg::G_BLANK;
  import discharge_pkg::G_DETECT;
  import discharge_pkg::G_DONE;
  import discharge_pkg::QUAL_BD;
  import discharge_pkg::QUAL_SHORT;
  import discharge_pkg::NUM_QUAL;

  gap_state_e state_reg;

  logic signed [DATA_W-1:0] bd_cur_reg;
  logic signed [DATA_W-1:0] bd_vol_reg;
  logic signed [DATA_W-1:0] deion_vol_reg;
  logic [CNT_W-1:0] bd_time_reg;
  logic [CNT_W-1:0] short_time_reg;
  logic [CNT_W-1:0] blank_time_reg;
  logic [CNT_W-1:0] timeout_reg;
  logic [CNT_W-1:0] ign_cnt_reg;
  logic [CNT_W-1:0] blank_cnt_reg;

  logic             in_window;
  logic             in_deion;
  logic             cur_ok;
  logic [CNT_W:0]   ign_plus1;
  logic [CNT_W:0]   blank_plus1;
  logic [CNT_W-1:0] ign_next;
  logic [CNT_W-1:0] blank_next;
  logic             timeout_hit;
  logic             blank_done;

  logic [NUM_QUAL-1:0] qual_cond;
  logic [NUM_QUAL-1:0] qual_hit;
  logic [CNT_W-1:0]    qual_thr [NUM_QUAL];
  logic                qual_en;

  assign in_window = (current_state == S_WAIT_BREAKDOWN);
  assign in_deion  = (current_state == S_DEION) || (current_state == S_DEION_SINGLE_BUCK);
  assign cur_ok    = ($signed(sample_current) >= bd_cur_reg);

  assign qual_cond[QUAL_BD]    = cur_ok && ($signed(sample_voltage) >= deion_vol_reg)
                                        && ($signed(sample_voltage) <= bd_vol_reg);
  assign qual_cond[QUAL_SHORT] = cur_ok && ($signed(sample_voltage) < deion_vol_reg);
  assign qual_thr[QUAL_BD]     = bd_time_reg;
  assign qual_thr[QUAL_SHORT]  = short_time_reg;
  assign qual_en               = (state_reg == G_DETECT) && in_window;

  // One extra bit on the increments gives the saturation carry for free.
  assign ign_plus1   = {1'b0, ign_cnt_reg} + (CNT_W+1)'(1);
  assign blank_plus1 = {1'b0, blank_cnt_reg} + (CNT_W+1)'(1);
  assign ign_next    = ign_plus1[CNT_W] ? ign_cnt_reg : ign_plus1[CNT_W-1:0];
  assign blank_next  = blank_plus1[CNT_W] ? blank_cnt_reg : blank_plus1[CNT_W-1:0];
  assign timeout_hit = (timeout_reg != '0) && (ign_plus1 == {1'b0, timeout_reg});
  assign blank_done  = (blank_plus1 >= {1'b0, blank_time_reg});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUAL; gi++) begin : g_qual
      run_length_qualifier #(.CNT_W(CNT_W)) u_qual (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (qual_en),
        .cond      (qual_cond[gi]),
        .threshold (qual_thr[gi]),
        .qualified (qual_hit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= G_IDLE;
      bd_cur_reg      <= '0;
      bd_vol_reg      <= '0;
      deion_vol_reg   <= '0;
      bd_time_reg     <= '0;
      short_time_reg  <= '0;
      blank_time_reg  <= '0;
      timeout_reg     <= '0;
      ign_cnt_reg     <= '0;
      blank_cnt_reg   <= '0;
      is_breakdown    <= 1'b0;
      is_short        <= 1'b0;
      is_open_timeout <= 1'b0;
      result_valid    <= 1'b0;
      ignition_delay  <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state_reg)
        G_IDLE: begin
          if (in_window) begin
            bd_cur_reg     <= $signed(cfg_bd_cur);
            bd_vol_reg     <= $signed(cfg_bd_vol);
            deion_vol_reg  <= $signed(cfg_deion_vol);
            bd_time_reg    <= cfg_bd_time;
            short_time_reg <= cfg_short_time;
            blank_time_reg <= cfg_blank_time;
            timeout_reg    <= cfg_timeout;
            ign_cnt_reg    <= '0;
            blank_cnt_reg  <= '0;
            state_reg      <= G_BLANK;
          end
        end
        G_BLANK, G_DETECT: begin
          if (!in_window) begin
            state_reg <= G_IDLE;
          end else begin
            ign_cnt_reg <= ign_next;
            if (state_reg == G_BLANK) blank_cnt_reg <= blank_next;
            // Qualification outranks a timeout expiring on the same edge.
            if (qual_hit[QUAL_BD]) begin
              is_breakdown   <= 1'b1;
              result_valid   <= 1'b1;
              ignition_delay <= ign_next;
              state_reg      <= G_DONE;
            end else if (qual_hit[QUAL_SHORT]) begin
              is_short       <= 1'b1;
              result_valid   <= 1'b1;
              ignition_delay <= ign_next;
              state_reg      <= G_DONE;
            end else if (timeout_hit) begin
              is_open_timeout <= 1'b1;
              result_valid    <= 1'b1;
              ignition_delay  <= timeout_reg;
              state_reg       <= G_DONE;
            end else if ((state_reg == G_BLANK) && blank_done) begin
              state_reg <= G_DETECT;
            end
          end
        end
        G_DONE: begin
          if (in_deion) begin
            is_breakdown    <= 1'b0;
            is_short        <= 1'b0;
            is_open_timeout <= 1'b0;
            state_reg       <= G_IDLE;
          end
        end
        default: state_reg <= G_IDLE;
      endcase
    end
  end

endmodule

// File: doc/discharge_gap_classifier.md
Name: discharge_gap_classifier

Overview:
Parametrised successor to the single-threshold breakdown detector in the EDM discharge-control path. It watches ADC current and voltage while the discharge FSM is in S_WAIT_BREAKDOWN and classifies the gap as one of:
- normal breakdown;
- short circuit;
- open-circuit timeout.
It also measures the ignition delay. All thresholds are run-time inputs, captured at window start, so the host can retune per waveform without resynthesis.

Parameters:
DATA_W, 16, width of signed ADC samples and voltage/current thresholds
CNT_W, 16, width of all timers, the ignition-delay result and time thresholds
S_WAIT_BREAKDOWN, 8'b00000001, current_state code that opens a detection window
S_DEION, 8'b10000000, deion state code that clears results
S_DEION_SINGLE_BUCK, 8'b00000000, second deion state code that clears results

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset, synchronous, active-low
sample_current  in  DATA_W  signed gap current (A)
sample_voltage  in  DATA_W  signed gap voltage (V)
current_state  in  8  discharge FSM state
cfg_bd_cur  in  DATA_W  signed minimum current for breakdown and short
cfg_bd_vol  in  DATA_W  signed upper voltage bound for breakdown
cfg_deion_vol  in  DATA_W  signed lower voltage bound for breakdown; below it the gap is "short"
cfg_bd_time  in  CNT_W  consecutive cycles needed to qualify a breakdown (0 treated as 1)
cfg_short_time  in  CNT_W  consecutive cycles needed to qualify a short (0 treated as 1)
cfg_blank_time  in  CNT_W  cycles ignored at window start to cover the voltage rise slope
cfg_timeout  in  CNT_W  open-circuit timeout in cycles from window start; 0 disables it
is_breakdown  out  1  sticky breakdown flag
is_short  out  1  sticky short flag
is_open_timeout  out  1  sticky timeout flag
result_valid  out  1  one-cycle pulse when a classification is made
ignition_delay  out  CNT_W  cycles from window start to classification; saturating

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, all counters 0.
- FSM states: IDLE, BLANK, DETECT, DONE.
- IDLE -> BLANK when current_state==S_WAIT_BREAKDOWN.
  - On that edge: cfg_* copied to shadow registers, ign_cnt=0, blank_cnt=0.
  - Mid-window changes to cfg_* have no effect.
- BLANK:
  - ign_cnt and blank_cnt increment each cycle.
  - -> DETECT on the edge where blank_cnt reaches shadow blank_time.
  - blank_time=0 -> DETECT on the edge after entry.
  - No qualification counting in BLANK.
- DETECT conditions, all compares signed:
  - Breakdown condition: I>=bd_cur AND deion_vol<=V<=bd_vol.
  - Short condition: I>=bd_cur AND V<deion_vol.
  - The two are mutually exclusive. bd_cnt or short_cnt increments while its condition holds and clears to 0 otherwise.
- Qualification:
  - Condition sampled true on N consecutive DETECT cycles (N = time threshold) -> flag high on the edge that samples the Nth cycle. DONE is entered on that same edge.
  - result_valid pulses high for exactly that one cycle.
  - ignition_delay latches ign_cnt+1 on that edge (saturating at 2^CNT_W-1).
- Timeout: in BLANK or DETECT, if timeout!=0 and ign_cnt+1==timeout -> is_open_timeout=1, result_valid pulse, DONE. ignition_delay latches the timeout value.
- Simultaneous qualification and timeout on the same edge: breakdown or short wins; the timeout flag stays 0.
- Abort: in BLANK or DETECT, current_state leaving S_WAIT_BREAKDOWN -> IDLE. No flag set, no result_valid; ignition_delay holds its old value.
- DONE:
  - Flags and ignition_delay hold while current_state is any non-deion state, e.g. BUCK or RES discharge.
  - current_state==S_DEION or S_DEION_SINGLE_BUCK -> all three flags clear, -> IDLE on the same edge. ignition_delay holds.
  - DONE ignores S_WAIT_BREAKDOWN until it has passed through deion.
- At most one of the three flags is ever high.
- All counters saturate; there is no wrap-around.
- Reset mid-window returns to IDLE with zero outputs on the next edge.

Decomposition:
- Shared package discharge_pkg holds:
  - current_state codes: S_WAIT_BREAKDOWN, S_DEION, S_DEION_SINGLE_BUCK, S_BUCK_INTERLEAVE, S_RES_DISCHARGE;
  - waveform bit indices: BUCK_OR_RES_BIT=15, CONTINUE_OR_SINGLE_BIT=14, OPEN_OR_CLOSE_BIT=13;
  - classifier FSM encoding.
- One natural sub-module, run_length_qualifier: a saturating consecutive-cycle counter with a threshold and a one-shot "qualified" output. It is instantiated twice, once for breakdown and once for short.

Test Plan:
1. blank=400, bd_time=10, bd_cur=10, deion=8, bd_vol=35. After blank, drive I=20, V=25 for 10 cycles -> is_breakdown and result_valid high on the 10th sampled cycle; ignition_delay=410 if the condition starts at the first DETECT cycle.
2. Drive I=20, V=25 during BLANK only, then I=0 -> no flag. With timeout=1000 -> is_open_timeout=1 at ign count 1000, ignition_delay=1000.
3. short_time=5; after blank drive I=50, V=3 for 5 cycles -> is_short=1, is_breakdown=0. Then current_state=S_DEION -> all flags 0, FSM IDLE.
4. Breakdown condition held 9 cycles, broken 1 cycle, then held 10 cycles -> qualification only after the second run, with ignition_delay counted from window start.
5. Breakdown qualifies on the same edge the timeout expires -> is_breakdown=1, is_open_timeout=0.
6. Abort and reset:
   - current_state -> S_BUCK_INTERLEAVE mid-DETECT -> IDLE, no result_valid.
   - rst_n=0 for one edge mid-window -> all outputs 0.
